// File: rtl/lab4_sys_net_adapter_pkg.sv
// Shared message formats and helpers for the cache<->network tag adapter.
package lab4_sys_net_adapter_pkg;

  // 4B cache request: {type, opaque, addr, len, data}
  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  // 4B cache response: {type, opaque, test, len, data}
  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // 12-bit network header; opaque carries the adapter tag
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dest;
    logic [7:0] opaque;
  } net_msg_hdr_t;

  typedef struct packed {
    net_msg_hdr_t hdr;
    mem_req_4B_t  payload;
  } net_req_msg_t;

  typedef struct packed {
    net_msg_hdr_t hdr;
    mem_resp_4B_t payload;
  } net_resp_msg_t;

  // One outstanding request: original opaque and the bank it was sent to
  typedef struct packed {
    logic       valid;
    logic [7:0] opaque;
    logic [1:0] dest;
  } tag_entry_t;

  localparam int REQ_W   = $bits(mem_req_4B_t);
  localparam int RESP_W  = $bits(mem_resp_4B_t);
  localparam int NREQ_W  = $bits(net_req_msg_t);
  localparam int NRESP_W = $bits(net_resp_msg_t);

  // Index width for a table of n tags (at least one bit)
  function automatic int tag_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lab4_sys_tag_alloc.sv
// Tag allocator: valid bit-vector, lowest-free priority encoder, occupancy counter.
// A tag freed this cycle only becomes visible as free from the next cycle.
module lab4_sys_tag_alloc #(
  parameter int p_num_tags = 8,
  parameter int p_tw       = 3,
  parameter int p_cw       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc,
  input  logic            free,
  input  logic [p_tw-1:0] free_tag,
  output logic            avail,
  output logic [p_tw-1:0] alloc_tag,
  output logic [p_cw-1:0] num_out
);

  logic [p_num_tags-1:0] valid_q;
  logic [p_cw-1:0]       count_q;

  // Lowest-index free tag; scanning downward lets the lowest index win
  always_comb begin
    avail     = 1'b0;
    alloc_tag = '0;
    for (int i = p_num_tags - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        avail     = 1'b1;
        alloc_tag = p_tw'(i);
      end
    end
  end

  // Valid vector and occupancy; alloc and free always target different tags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      if (alloc) valid_q[alloc_tag] <= 1'b1;
      if (free)  valid_q[free_tag]  <= 1'b0;
      case ({alloc, free})
        2'b10:   count_q <= count_q + p_cw'(1);
        2'b01:   count_q <= count_q - p_cw'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign num_out = count_q;

endmodule

// File: rtl/lab4_sys_net_tag_adapter.sv
// Cache<->network adapter: tags outgoing requests, restores the original opaque
// on returning responses. Both directions are one-entry registered stages.
// Handshake: a transfer happens on a cycle where val && rdy are both high;
// a producer holding val keeps its message stable until that cycle.
module lab4_sys_net_tag_adapter
  import lab4_sys_net_adapter_pkg::*;
#(
  parameter int p_num_tags  = 8,
  parameter int p_num_banks = 4,
  parameter int p_bank_lsb  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      src_id,
  input  logic [REQ_W-1:0]                creq_msg,
  input  logic                            creq_val,
  output logic                            creq_rdy,
  output logic [NREQ_W-1:0]               nreq_msg,
  output logic                            nreq_val,
  input  logic                            nreq_rdy,
  input  logic [NRESP_W-1:0]              nresp_msg,
  input  logic                            nresp_val,
  output logic                            nresp_rdy,
  output logic [RESP_W-1:0]               cresp_msg,
  output logic                            cresp_val,
  input  logic                            cresp_rdy,
  output logic [$clog2(p_num_tags+1)-1:0] num_out,
  output logic                            err
);

  localparam int TW = tag_width(p_num_tags);
  localparam int CW = $clog2(p_num_tags + 1);
  localparam int BW = (p_num_banks > 1) ? $clog2(p_num_banks) : 1;

  mem_req_4B_t   creq;
  net_resp_msg_t nresp;
  net_req_msg_t  rq_q, rq_d;
  net_resp_msg_t rs_q;
  mem_resp_4B_t  rs_d;
  logic          rq_full, rs_full, err_q;
  tag_entry_t    table_q [p_num_tags];

  logic          avail;
  logic [TW-1:0] alloc_tag, rsp_tag;
  logic [1:0]    dest;
  logic          creq_fire, nresp_fire, in_range, hit, deliver;
  tag_entry_t    entry;
  logic          unused_bits;

  assign creq  = creq_msg;
  assign nresp = nresp_msg;

  assign creq_rdy   = avail && (!rq_full || nreq_rdy);
  assign creq_fire  = creq_val && creq_rdy;
  assign nresp_rdy  = !rs_full || cresp_rdy;
  assign nresp_fire = nresp_val && nresp_rdy;

  // Response lookup; out-of-range tags never touch the table
  assign rsp_tag  = nresp.hdr.opaque[TW-1:0];
  assign in_range = ({1'b0, nresp.hdr.opaque} < 9'(p_num_tags));
  assign entry    = table_q[rsp_tag];
  assign hit      = in_range && entry.valid;
  assign deliver  = nresp_fire && hit;

  // The returning header's dest is our own id; nothing to do with it
  assign unused_bits = ^nresp.hdr.dest;

  lab4_sys_tag_alloc #(
    .p_num_tags (p_num_tags),
    .p_tw       (TW),
    .p_cw       (CW)
  ) u_alloc (
    .clk       (clk),
    .reset     (reset),
    .alloc     (creq_fire),
    .free      (deliver),
    .free_tag  (rsp_tag),
    .avail     (avail),
    .alloc_tag (alloc_tag),
    .num_out   (num_out)
  );

  // Bank select from the address; single-bank systems always target bank 0
  always_comb begin
    dest = '0;
    if (p_num_banks > 1) dest[BW-1:0] = creq.addr[p_bank_lsb +: BW];
  end

  // Network request: tag replaces opaque in both header and payload
  always_comb begin
    rq_d                = '0;
    rq_d.hdr.src        = src_id;
    rq_d.hdr.dest       = dest;
    rq_d.hdr.opaque     = 8'(alloc_tag);
    rq_d.payload        = creq;
    rq_d.payload.opaque = 8'(alloc_tag);
  end

  // Cache response: restore the opaque saved at allocation
  always_comb begin
    rs_d        = nresp.payload;
    rs_d.opaque = entry.opaque;
  end

  // Request pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq_full <= 1'b0;
      rq_q    <= '0;
    end else if (creq_fire) begin
      rq_full <= 1'b1;
      rq_q    <= rq_d;
    end else if (nreq_rdy) begin
      rq_full <= 1'b0;
    end
  end

  // Response pipeline register; dropped responses never load it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_full <= 1'b0;
      rs_q    <= '0;
    end else if (deliver) begin
      rs_full     <= 1'b1;
      rs_q.hdr    <= nresp.hdr;
      rs_q.payload <= rs_d;
    end else if (cresp_rdy) begin
      rs_full <= 1'b0;
    end
  end

  // Tag table: fill on allocation, invalidate on delivered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < p_num_tags; i++) table_q[i] <= '0;
    end else begin
      if (creq_fire) table_q[alloc_tag] <= '{valid: 1'b1, opaque: creq.opaque, dest: dest};
      if (deliver)   table_q[rsp_tag].valid <= 1'b0;
    end
  end

  // Sticky error: unknown tag, or response from a bank other than the one asked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if (nresp_fire && (!hit || (nresp.hdr.src != entry.dest))) err_q <= 1'b1;
  end

  assign nreq_msg  = rq_q;
  assign nreq_val  = rq_full;
  assign cresp_msg = rs_q.payload;
  assign cresp_val = rs_full;
  assign err       = err_q;

endmodule
